sample_stream_capture: RTL
==========================

// Module: sample_stream_capture
// PURPOSE
//  Sink side of the sample clock: detects rising edges of sample_clk (ACLK-domain, registered by the
//  divider block) and captures sample_data on each one into an AXI4-Stream master for the cyclic DMA.
//  Buffers samples in a small FIFO and marks every pkt_len-th beat with TLAST (one DMA period).
//  Reports sticky overflow when the DMA stalls long enough to fill the FIFO.
// PARAMETERS
//  C_M_AXIS_DATA_WIDTH  32  width of sample_data / M_AXIS_TDATA
//  C_FIFO_DEPTH         16  FIFO entries; power of 2, >= 2
//  C_PKT_LEN_WIDTH      16  width of pkt_len and beat counter
// PORTS
//  ACLK           in   1      clock
//  ARESETN        in   1      synchronous, active-low reset
//  sample_clk     in   1      sample strobe source, ACLK-synchronous level signal
//  sample_data    in   DW     sample value, valid in the cycle the rising edge is detected
//  enable         in   1      capture enable
//  pkt_len        in   PLW    beats per packet; 0 treated as 1
//  M_AXIS_TVALID  out  1      stream valid
//  M_AXIS_TREADY  in   1      stream ready
//  M_AXIS_TDATA   out  DW     captured sample
//  M_AXIS_TLAST   out  1      last beat of packet
//  overflow       out  1      sticky: at least one sample dropped
//  fifo_level     out  log2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: TVALID=0, TLAST=0, TDATA=0, overflow=0, fifo_level=0, beat counter=0, sample_clk_d=0,
//   enable_d=0. Reset mid-packet discards FIFO contents and any in-progress beat.
//  Edge detect: sample_clk_d <= sample_clk each cycle; rise = sample_clk & ~sample_clk_d.
//   A sample_clk held high gives exactly one capture; high-for-1-cycle pulses are captured.
//  Capture: in cycle N with rise & enable, write {last, sample_data} to FIFO; TVALID high in N+1
//   when FIFO was empty (1-cycle latency, first-word-fall-through output).
//  last = (beat_cnt == eff_len-1), eff_len = (pkt_len==0) ? 1 : pkt_len. On accepted write
//   beat_cnt <= last ? 0 : beat_cnt+1. pkt_len sampled at each write; changing it mid-packet
//   takes effect immediately (if beat_cnt >= new eff_len-1, the next write is last, counter wraps to 0).
//  Full: write accepted if level < DEPTH, or level == DEPTH and a pop occurs same cycle.
//   Otherwise sample dropped, beat_cnt unchanged, overflow <= 1.
//  overflow cleared only by reset or by enable rising edge (enable & ~enable_d).
//  enable low: no captures; beat_cnt <= 0; FIFO keeps draining; no TLAST inserted.
//  enable rising: beat_cnt=0, overflow cleared; a sample_clk rise in that same cycle is captured
//   as beat 0.
//  AXIS: pop when TVALID & TREADY. TDATA/TLAST stable while TVALID & ~TREADY. TVALID never drops
//   without a handshake. Simultaneous push and pop: level unchanged, both occur.
//  fifo_level: registered occupancy, 0..DEPTH; updated one cycle after push/pop.
//  Pointers: log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ & rest equal.
// STRUCTURE
//  Shared package: clog2 function, AXIS beat struct width constant (DW+1), default depth.
//  Sub-module sync_fifo (DEPTH, WIDTH=DW+1): push/pop, full/empty, level, FWFT output.
//  Top: edge detectors, beat counter, overflow flag, AXIS mapping.
// TESTING
//  1. pkt_len=4, sample_clk toggled every 2 ACLK, TREADY=1, data 0,1,2.. -> beats 0..7, TLAST on 3,7.
//  2. TREADY=0, 20 edges, DEPTH=16 -> 16 entries held (0..15), overflow=1, samples 16..19 lost.
//     Then TREADY=1 -> 0..15 drained in order, level reaches 0.
//  3. pkt_len=0 -> every beat has TLAST=1; pkt_len=1 identical.
//  4. sample_clk held high 10 cycles -> exactly one beat; 1-cycle pulse -> one beat.
//  5. enable dropped after beat 2 of pkt_len=4, re-raised -> next beat is beat 0; overflow cleared.
//  6. FIFO full with TREADY=1 and edge same cycle -> write accepted, no overflow, level stays 16.
//  7. ARESETN low mid-packet with 5 entries -> TVALID=0, level=0 next cycle, next beat is beat 0.

Source files
------------

// File: rtl/sample_stream_capture_pkg.sv
// Shared constants and helpers for the sample stream capture block:
// default widths, the beat width (data plus TLAST) and a constant log2.
package sample_stream_capture_pkg;

  localparam int DEFAULT_DATA_WIDTH    = 32;
  localparam int DEFAULT_FIFO_DEPTH    = 16;
  localparam int DEFAULT_PKT_LEN_WIDTH = 16;
  localparam int DEFAULT_BEAT_WIDTH    = DEFAULT_DATA_WIDTH + 1;

  // Ceiling log2, usable in parameter and port-width expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // A stored beat is {last, data}.
  function automatic int beat_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/sample_stream_capture_if.sv
// AXI4-Stream bundle carrying captured samples from the capture block to the DMA.
interface sample_stream_capture_if #(
  parameter int DW = 32
);
  logic          TVALID;
  logic          TREADY;
  logic [DW-1:0] TDATA;
  logic          TLAST;

  modport master (output TVALID, output TDATA, output TLAST, input TREADY);
  modport slave  (input TVALID, input TDATA, input TLAST, output TREADY);
endinterface

// File: rtl/sample_stream_capture_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy.
// Pointers carry one extra wrap bit so full and empty need no separate flag.
module sync_fifo
  import sample_stream_capture_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int WIDTH = DEFAULT_BEAT_WIDTH
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // NOTE: combinational logic uses blocking '=' with a default for every
  // output first (no latches); clocked state below uses non-blocking '<='.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    dout  = mem_q[rd_ptr_q[AW-1:0]];
    level = level_q;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only ever read
  // after being written, and an unreset array maps onto plain RAM.
  always_ff @(posedge ACLK) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sample_stream_capture.sv
// Captures sample_data on each rising edge of sample_clk into a FIFO-backed
// AXI4-Stream master, tagging every pkt_len-th beat with TLAST.
module sample_stream_capture
  import sample_stream_capture_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int C_FIFO_DEPTH        = DEFAULT_FIFO_DEPTH,
  parameter int C_PKT_LEN_WIDTH     = DEFAULT_PKT_LEN_WIDTH
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  input  logic                               sample_clk,
  input  logic [C_M_AXIS_DATA_WIDTH-1:0]     sample_data,
  input  logic                               enable,
  input  logic [C_PKT_LEN_WIDTH-1:0]         pkt_len,
  sample_stream_capture_if.master            M_AXIS,
  output logic                               overflow,
  output logic [clog2(C_FIFO_DEPTH):0]       fifo_level
);

  localparam int DW  = C_M_AXIS_DATA_WIDTH;
  localparam int PLW = C_PKT_LEN_WIDTH;
  localparam int BW  = beat_width(DW);

  logic           sample_clk_q, sample_clk_d;
  logic           enable_q, enable_d;
  logic           overflow_q, overflow_d;
  logic [PLW-1:0] beat_cnt_q, beat_cnt_d;
  logic [PLW-1:0] eff_len, cnt_base;
  logic           rise, en_rise, want_push, push_ok, pop, last;
  logic           fifo_full, fifo_empty;
  logic [BW-1:0]  fifo_dout;

  always_comb begin
    sample_clk_d = sample_clk;
    enable_d     = enable;
    rise         = sample_clk & ~sample_clk_q;
    en_rise      = enable & ~enable_q;
    eff_len      = (pkt_len == '0) ? PLW'(1) : pkt_len;
    // A fresh enable starts a new packet even if a sample lands this cycle.
    cnt_base     = en_rise ? '0 : beat_cnt_q;
    // '>=' lets a mid-packet shrink of pkt_len close the packet at once.
    last         = (cnt_base >= eff_len - PLW'(1));
    want_push    = rise & enable;
    pop          = ~fifo_empty & M_AXIS.TREADY;
    push_ok      = want_push & (~fifo_full | pop);

    beat_cnt_d = cnt_base;
    if (!enable)      beat_cnt_d = '0;
    else if (push_ok) beat_cnt_d = last ? '0 : cnt_base + PLW'(1);

    overflow_d = (overflow_q & ~en_rise) | (want_push & ~push_ok);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      sample_clk_q <= 1'b0;
      enable_q     <= 1'b0;
      overflow_q   <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      sample_clk_q <= sample_clk_d;
      enable_q     <= enable_d;
      overflow_q   <= overflow_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  sync_fifo #(
    .DEPTH (C_FIFO_DEPTH),
    .WIDTH (BW)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .push    (push_ok),
    .pop     (pop),
    .din     ({last, sample_data}),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Data and TLAST read as zero whenever no beat is offered.
  assign M_AXIS.TVALID = ~fifo_empty;
  assign M_AXIS.TDATA  = fifo_empty ? '0 : fifo_dout[DW-1:0];
  assign M_AXIS.TLAST  = ~fifo_empty & fifo_dout[BW-1];
  assign overflow      = overflow_q;

endmodule
